// File: rtl/mux_result_skid_pkg.sv
// Shared types and constants for the mux result skid buffer.
package mux_result_skid_pkg;

  // Default width of the captured 3:1 mux Result bus.
  localparam int DATA_W = 16;

  // Occupancy states; the encoding doubles as the entry count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  // Number of buffered entries held in a given state.
  function automatic logic [1:0] count_of(input state_t s);
    case (s)
      ONE:     count_of = 2'd1;
      FULL:    count_of = 2'd2;
      default: count_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/mux_result_skid_if.sv
// Upstream/downstream handshake bundle for the mux result skid buffer.
interface mux_result_skid_if
  import mux_result_skid_pkg::*;
#(
  parameter int WIDTH = DATA_W
);

  logic [WIDTH-1:0] din;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dout;
  logic             out_valid;
  logic             out_ready;
  logic             flush;
  logic [1:0]       count;

  // Driver side: produces upstream data, consumes downstream data.
  modport master (
    output din, in_valid, out_ready, flush,
    input  in_ready, dout, out_valid, count
  );

  // Buffer side.
  modport slave (
    input  din, in_valid, out_ready, flush,
    output in_ready, dout, out_valid, count
  );

endinterface

// File: rtl/mux_result_skid.sv
// Two-entry skid buffer that registers the mux Result bus. Main always
// drives Dout; Skid catches the word that arrives while Main is stalled.
// in_ready, out_valid and count are flops derived from the next state, so
// there is no combinational path from out_ready to in_ready.
module mux_result_skid
  import mux_result_skid_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  mux_result_skid_if.slave  bus
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [1:0]       count_q, count_d;
  logic             in_xfer;
  logic             out_xfer;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.count     = count_q;
  assign bus.dout      = main_q;

  // Next-state and next-data selection from the two handshakes; flush wins.
  always_comb begin
    in_xfer  = bus.in_valid & in_ready_q;
    out_xfer = out_valid_q & bus.out_ready;
    state_d  = state_q;
    main_d   = main_q;
    skid_d   = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          main_d  = bus.din;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          main_d = bus.din;
        end else if (in_xfer) begin
          skid_d  = bus.din;
          state_d = FULL;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_xfer) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (bus.flush) begin
      state_d = EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
    in_ready_d  = (state_d != FULL);
    out_valid_d = (state_d != EMPTY);
    count_d     = count_of(state_d);
  end

  // Occupancy FSM with its decoded handshake outputs held in flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      count_q     <= 2'd0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      count_q     <= count_d;
    end
  end

  // Main and Skid data registers, cleared so they are never X after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

endmodule

// File: tb/tb_mux_result_skid.sv
// Self-checking bench for mux_result_skid against a queue-based FIFO model.
module tb_mux_result_skid;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  logic [15:0] mq[$];

  mux_result_skid_if #(.WIDTH(16)) bus();

  mux_result_skid #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of inputs, advance past the rising edge and update the
  // model: the buffer is a FIFO of at most two words, flush empties it.
  task automatic step(input logic [15:0] d, input logic iv, input logic ordy, input logic fl);
    bit in_x;
    bit out_x;
    bus.din       = d;
    bus.in_valid  = iv;
    bus.out_ready = ordy;
    bus.flush     = fl;
    in_x  = iv && (mq.size() < 2);
    out_x = ordy && (mq.size() > 0);
    @(posedge clk);
    if (fl) begin
      mq.delete();
    end else begin
      if (out_x) void'(mq.pop_front());
      if (in_x) mq.push_back(d);
    end
    #1;
  endtask

  // Reset values must appear while rst_n is still low.
  task automatic test_reset();
    rst_n         = 1'b0;
    bus.din       = 16'hBEEF;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
    mq.delete();
    #12;
    checks++;
    if (bus.count !== 2'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", bus.count); end
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    checks++;
    if (bus.dout !== 16'd0) begin errors++; $display("[TB] FAIL reset_dout: got %0d expected 0", bus.dout); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // One word in with the consumer ready: visible one cycle later.
  task automatic test_single();
    step(16'd5, 1'b1, 1'b1, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_out_valid: got %b expected 1", bus.out_valid); end
    checks++;
    if (bus.dout !== 16'd5) begin errors++; $display("[TB] FAIL single_dout: got %0d expected 5", bus.dout); end
    checks++;
    if (bus.count !== 2'd1) begin errors++; $display("[TB] FAIL single_count: got %0d expected 1", bus.count); end
    step(16'd0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.count !== 2'd0) begin errors++; $display("[TB] FAIL single_drain_count: got %0d expected 0", bus.count); end
  endtask

  // Stall the consumer, fill both entries, then drain in order.
  task automatic test_fill_drain();
    step(16'd5, 1'b1, 1'b0, 1'b0);
    step(16'd10, 1'b1, 1'b0, 1'b0);
    checks++;
    if (bus.count !== 2'd2) begin errors++; $display("[TB] FAIL fill_count: got %0d expected 2", bus.count); end
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL fill_in_ready: got %b expected 0", bus.in_ready); end
    step(16'd99, 1'b1, 1'b0, 1'b0);
    checks++;
    if (bus.dout !== 16'd5) begin errors++; $display("[TB] FAIL full_ignore_dout: got %0d expected 5", bus.dout); end
    step(16'd77, 1'b1, 1'b1, 1'b0);
    checks++;
    if (bus.dout !== 16'd10) begin errors++; $display("[TB] FAIL drain_second: got %0d expected 10", bus.dout); end
    checks++;
    if (bus.count !== 2'd1) begin errors++; $display("[TB] FAIL drain_count1: got %0d expected 1", bus.count); end
    step(16'd0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.count !== 2'd0) begin errors++; $display("[TB] FAIL drain_count0: got %0d expected 0", bus.count); end
  endtask

  // Continuous flow: one word per cycle, never back-pressured.
  task automatic test_back_to_back();
    logic [15:0] words [3];
    words[0] = 16'd5;
    words[1] = 16'd10;
    words[2] = 16'd15;
    for (int i = 0; i < 3; i++) begin
      step(words[i], 1'b1, 1'b1, 1'b0);
      checks++;
      if (bus.dout !== words[i]) begin errors++; $display("[TB] FAIL stream_dout%0d: got %0d expected %0d", i, bus.dout, words[i]); end
      checks++;
      if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL stream_in_ready%0d: got %b expected 1", i, bus.in_ready); end
    end
    step(16'd0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL stream_end_valid: got %b expected 0", bus.out_valid); end
  endtask

  // Flush while full discards everything including the offered word.
  task automatic test_flush();
    step(16'd5, 1'b1, 1'b0, 1'b0);
    step(16'd10, 1'b1, 1'b0, 1'b0);
    step(16'd15, 1'b1, 1'b0, 1'b1);
    checks++;
    if (bus.count !== 2'd0) begin errors++; $display("[TB] FAIL flush_count: got %0d expected 0", bus.count); end
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_out_valid: got %b expected 0", bus.out_valid); end
    step(16'd0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_no_15: got %b expected 0", bus.out_valid); end
    step(16'd21, 1'b1, 1'b0, 1'b0);
    step(16'd22, 1'b1, 1'b1, 1'b1);
    checks++;
    if (bus.count !== 2'd0) begin errors++; $display("[TB] FAIL flush_one_count: got %0d expected 0", bus.count); end
  endtask

  // Asynchronous reset between edges while holding a word.
  task automatic test_async_reset();
    step(16'd7, 1'b1, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    mq.delete();
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL arst_out_valid: got %b expected 0", bus.out_valid); end
    checks++;
    if (bus.dout !== 16'd0) begin errors++; $display("[TB] FAIL arst_dout: got %0d expected 0", bus.dout); end
    checks++;
    if (bus.count !== 2'd0) begin errors++; $display("[TB] FAIL arst_count: got %0d expected 0", bus.count); end
    rst_n = 1'b1;
    step(16'd15, 1'b1, 1'b0, 1'b0);
    checks++;
    if (bus.dout !== 16'd15) begin errors++; $display("[TB] FAIL arst_push_dout: got %0d expected 15", bus.dout); end
    step(16'd0, 1'b0, 1'b1, 1'b0);
  endtask

  // Randomized handshakes against the FIFO model.
  task automatic test_random();
    logic [15:0] d;
    logic iv, ordy, fl;
    int   exp_cnt;
    for (int i = 0; i < 1000; i++) begin
      d    = 16'($urandom);
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      fl   = ($urandom_range(0, 49) == 0);
      step(d, iv, ordy, fl);
      exp_cnt = mq.size();
      checks++;
      if (bus.count > 2'd2) begin errors++; $display("[TB] FAIL rand_count_bound cyc%0d: got %0d expected <=2", i, bus.count); end
      checks++;
      if (int'(bus.count) !== exp_cnt) begin errors++; $display("[TB] FAIL rand_count cyc%0d: got %0d expected %0d", i, bus.count, exp_cnt); end
      checks++;
      if (bus.in_ready !== (exp_cnt < 2)) begin errors++; $display("[TB] FAIL rand_in_ready cyc%0d: got %b expected %b", i, bus.in_ready, (exp_cnt < 2)); end
      checks++;
      if (bus.out_valid !== (exp_cnt > 0)) begin errors++; $display("[TB] FAIL rand_out_valid cyc%0d: got %b expected %b", i, bus.out_valid, (exp_cnt > 0)); end
      if (exp_cnt > 0) begin
        checks++;
        if (bus.dout !== mq[0]) begin errors++; $display("[TB] FAIL rand_dout cyc%0d: got %0d expected %0d", i, bus.dout, mq[0]); end
      end
    end
  endtask

  // Scenario sequence and summary.
  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_single();
    test_fill_drain();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
